xmit_frame_scheduler: RTL and testbench



---
 rtl/xmit_sched_pkg.sv | 35 +++
 rtl/xmit_sched_arb.sv | 47 ++++
 rtl/xmit_frame_scheduler.sv | 176 +++++++++++++++++
 tb/tb_xmit_frame_scheduler.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xmit_sched_pkg.sv
// Shared types and helpers for the transmit frame scheduler.
// Contents: scheduler state enum, length-counter width, control-word field
// positions and the control-word validity check.
package xmit_sched_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArb,
    StXfer,
    StDiscard,
    StGap
  } sched_state_e;

  localparam int unsigned LEN_W      = 12;
  localparam int unsigned CTRL_W     = 24;
  localparam int unsigned LEN_LO_LSB = 0;
  localparam int unsigned LEN_LO_MSB = 11;
  localparam int unsigned LEN_HI_LSB = 12;
  localparam int unsigned LEN_HI_MSB = 23;

  // Both length copies must agree and fall inside [min_len, max_len].
  // A zero length is never transmittable, whatever min_len says.
  function automatic logic ctrl_len_ok(input logic [CTRL_W-1:0] word,
                                       input int unsigned       min_len,
                                       input int unsigned       max_len);
    logic [LEN_W-1:0] len_lo;
    logic [LEN_W-1:0] len_hi;
    int unsigned      len;
    len_lo = word[LEN_LO_MSB:LEN_LO_LSB];
    len_hi = word[LEN_HI_MSB:LEN_HI_LSB];
    len    = 32'(len_lo);
    return (len_lo == len_hi) && (len >= min_len) && (len <= max_len) && (len != 0);
  endfunction

endpackage

// File: rtl/xmit_sched_arb.sv
// Strict-priority hi/lo grant selection with an anti-starvation limit.
// Ports:
//   clk_sys, reset      clock and asynchronous active-high reset
//   hi_ctrl_empty       hi control FIFO empty
//   lo_ctrl_empty       lo control FIFO empty
//   arb_en              scheduler is in its arbitration cycle; commits the grant
//   grant_valid         at least one queue has a control word
//   grant_hi            1 = grant hi queue, 0 = grant lo queue
module xmit_sched_arb
  import xmit_sched_pkg::*;
#(
  parameter int unsigned MAX_HI_BURST = 4
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic hi_ctrl_empty,
  input  logic lo_ctrl_empty,
  input  logic arb_en,
  output logic grant_valid,
  output logic grant_hi
);

  localparam int unsigned STREAK_W = (MAX_HI_BURST > 0) ? $clog2(MAX_HI_BURST + 1) : 1;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_HI_BURST);

  logic [STREAK_W-1:0] hi_streak_q, hi_streak_d;

  always_comb begin
    grant_valid = !hi_ctrl_empty || !lo_ctrl_empty;
    grant_hi    = !hi_ctrl_empty && (lo_ctrl_empty || (hi_streak_q != STREAK_MAX));
    hi_streak_d = hi_streak_q;
    if (arb_en && grant_valid) begin
      // Only hi grants that made lo wait extend the streak.
      if (grant_hi && !lo_ctrl_empty) begin
        if (hi_streak_q != STREAK_MAX) hi_streak_d = hi_streak_q + 1'b1;
      end else begin
        hi_streak_d = '0;
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) hi_streak_q <= '0;
    else       hi_streak_q <= hi_streak_d;
  end

endmodule

// File: rtl/xmit_frame_scheduler.sv
// Transmit frame scheduler: pulls control words from the hi/lo show-ahead
// control FIFOs, validates them, and paces byte pops from the granted data
// FIFO into the PHY serializer. Malformed frames are drained without
// transmission; transmitted frames are followed by an inter-frame gap.
// Ports:
//   clk_sys, reset                 clock and asynchronous active-high reset
//   hi/lo_ctrl_empty, _data, _rd   control FIFO interfaces (show-ahead)
//   hi/lo_data_rd                  data FIFO byte pops
//   tx_byte_ready/_valid           serializer handshake
//   tx_sel, tx_sof, tx_eof         byte mux select and frame delimiters
//   m_discard_en                   current frame is being drained
//   sched_busy                     scheduler not idle
// Optional (macro SCHED_STATS_EN): stat_hi_frames, stat_lo_frames,
//   stat_discards saturating 16-bit event counters.
module xmit_frame_scheduler
  import xmit_sched_pkg::*;
#(
  parameter int unsigned MIN_LEN      = 64,
  parameter int unsigned MAX_LEN      = 1518,
  parameter int unsigned MAX_HI_BURST = 4,
  parameter int unsigned IFG_CYCLES   = 12
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              hi_ctrl_empty,
  input  logic [CTRL_W-1:0] hi_ctrl_data,
  output logic              hi_ctrl_rd,
  input  logic              lo_ctrl_empty,
  input  logic [CTRL_W-1:0] lo_ctrl_data,
  output logic              lo_ctrl_rd,
  output logic              hi_data_rd,
  output logic              lo_data_rd,
  input  logic              tx_byte_ready,
  output logic              tx_byte_valid,
  output logic              tx_sel,
  output logic              tx_sof,
  output logic              tx_eof,
  output logic              m_discard_en,
  output logic              sched_busy
`ifdef SCHED_STATS_EN
  ,
  output logic [15:0]       stat_hi_frames,
  output logic [15:0]       stat_lo_frames,
  output logic [15:0]       stat_discards
`endif
);

  localparam int unsigned GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

  sched_state_e      state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              sel_q, sel_d;
  logic              first_q, first_d;
  logic              arb_en, grant_valid, grant_hi, data_rd;
  logic [CTRL_W-1:0] ctrl_word;

  xmit_sched_arb #(
    .MAX_HI_BURST (MAX_HI_BURST)
  ) u_arb (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .hi_ctrl_empty (hi_ctrl_empty),
    .lo_ctrl_empty (lo_ctrl_empty),
    .arb_en        (arb_en),
    .grant_valid   (grant_valid),
    .grant_hi      (grant_hi)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    gap_d         = gap_q;
    sel_d         = sel_q;
    first_d       = first_q;
    arb_en        = 1'b0;
    hi_ctrl_rd    = 1'b0;
    lo_ctrl_rd    = 1'b0;
    data_rd       = 1'b0;
    tx_byte_valid = 1'b0;
    tx_sof        = 1'b0;
    tx_eof        = 1'b0;
    m_discard_en  = 1'b0;
    ctrl_word     = grant_hi ? hi_ctrl_data : lo_ctrl_data;

    unique case (state_q)
      StIdle: begin
        if (!hi_ctrl_empty || !lo_ctrl_empty) state_d = StArb;
      end
      StArb: begin
        arb_en = 1'b1;
        if (grant_valid) begin
          hi_ctrl_rd = grant_hi;
          lo_ctrl_rd = !grant_hi;
          sel_d      = grant_hi;
          cnt_d      = ctrl_word[LEN_LO_MSB:LEN_LO_LSB];
          first_d    = 1'b1;
          state_d    = ctrl_len_ok(ctrl_word, MIN_LEN, MAX_LEN) ? StXfer : StDiscard;
        end else begin
          state_d = StIdle;
        end
      end
      StXfer: begin
        if (tx_byte_ready) begin
          data_rd       = 1'b1;
          tx_byte_valid = 1'b1;
          tx_sof        = first_q;
          first_d       = 1'b0;
          cnt_d         = cnt_q - 1'b1;
          if (cnt_q == LEN_W'(1)) begin
            tx_eof  = 1'b1;
            gap_d   = '0;
            state_d = (IFG_CYCLES == 0) ? StIdle : StGap;
          end
        end
      end
      StDiscard: begin
        // Drain at full rate; the serializer never sees these bytes.
        m_discard_en = 1'b1;
        if (cnt_q != '0) begin
          data_rd = 1'b1;
          cnt_d   = cnt_q - 1'b1;
        end
        if (cnt_q <= LEN_W'(1)) state_d = StIdle;
      end
      StGap: begin
        if (gap_q == GAP_LAST) state_d = StIdle;
        else                   gap_d   = gap_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      gap_q   <= '0;
      sel_q   <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      sel_q   <= sel_d;
      first_q <= first_d;
    end
  end

  assign hi_data_rd = data_rd & sel_q;
  assign lo_data_rd = data_rd & ~sel_q;
  assign tx_sel     = sel_q;
  assign sched_busy = (state_q != StIdle);

`ifdef SCHED_STATS_EN
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      stat_hi_frames <= '0;
      stat_lo_frames <= '0;
      stat_discards  <= '0;
    end else begin
      if (tx_eof && sel_q && (stat_hi_frames != 16'hFFFF)) begin
        stat_hi_frames <= stat_hi_frames + 16'd1;
      end
      if (tx_eof && !sel_q && (stat_lo_frames != 16'hFFFF)) begin
        stat_lo_frames <= stat_lo_frames + 16'd1;
      end
      if (arb_en && (state_d == StDiscard) && (stat_discards != 16'hFFFF)) begin
        stat_discards <= stat_discards + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_xmit_frame_scheduler.sv
// Self-checking bench for xmit_frame_scheduler: models the control FIFOs,
// predicts the grant order and per-frame outcome into a scoreboard, and
// compares each completed or discarded frame against it.
module tb_xmit_frame_scheduler;

  localparam int unsigned MIN_LEN      = 64;
  localparam int unsigned MAX_LEN      = 1518;
  localparam int unsigned MAX_HI_BURST = 4;
  localparam int unsigned IFG_CYCLES   = 12;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        hi_ctrl_empty, lo_ctrl_empty;
  logic [23:0] hi_ctrl_data, lo_ctrl_data;
  logic        hi_ctrl_rd, lo_ctrl_rd, hi_data_rd, lo_data_rd;
  logic        tx_byte_ready, tx_byte_valid, tx_sel, tx_sof, tx_eof;
  logic        m_discard_en, sched_busy;
`ifdef SCHED_STATS_EN
  logic [15:0] stat_hi_frames, stat_lo_frames, stat_discards;
`endif

  always #5 clk_sys = ~clk_sys;

  xmit_frame_scheduler #(
    .MIN_LEN      (MIN_LEN),
    .MAX_LEN      (MAX_LEN),
    .MAX_HI_BURST (MAX_HI_BURST),
    .IFG_CYCLES   (IFG_CYCLES)
  ) dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .hi_ctrl_empty (hi_ctrl_empty),
    .hi_ctrl_data  (hi_ctrl_data),
    .hi_ctrl_rd    (hi_ctrl_rd),
    .lo_ctrl_empty (lo_ctrl_empty),
    .lo_ctrl_data  (lo_ctrl_data),
    .lo_ctrl_rd    (lo_ctrl_rd),
    .hi_data_rd    (hi_data_rd),
    .lo_data_rd    (lo_data_rd),
    .tx_byte_ready (tx_byte_ready),
    .tx_byte_valid (tx_byte_valid),
    .tx_sel        (tx_sel),
    .tx_sof        (tx_sof),
    .tx_eof        (tx_eof),
    .m_discard_en  (m_discard_en),
    .sched_busy    (sched_busy)
`ifdef SCHED_STATS_EN
    ,
    .stat_hi_frames (stat_hi_frames),
    .stat_lo_frames (stat_lo_frames),
    .stat_discards  (stat_discards)
`endif
  );

  typedef struct {
    bit          sel;
    int unsigned len;
    bit          discard;
  } frame_t;

  frame_t      exp_q[$];
  logic [23:0] hi_fifo[$], lo_fifo[$];
  logic [23:0] stage_hi[$], stage_lo[$];
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned m_streak = 0;

  // Monitor state
  bit          in_frame = 0, gap_active = 0, prev_disc = 0, cur_sel = 0;
  bit          hi_pop = 0, lo_pop = 0;
  int unsigned bytes = 0, disc_cycles = 0, gap_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic refresh();
    hi_ctrl_empty = (hi_fifo.size() == 0);
    lo_ctrl_empty = (lo_fifo.size() == 0);
    hi_ctrl_data  = (hi_fifo.size() != 0) ? hi_fifo[0] : 24'h0;
    lo_ctrl_data  = (lo_fifo.size() != 0) ? lo_fifo[0] : 24'h0;
  endtask

  function automatic bit word_good(input logic [23:0] w);
    int unsigned lo_len, hi_len;
    lo_len = 32'(w[11:0]);
    hi_len = 32'(w[23:12]);
    return (lo_len == hi_len) && (lo_len >= MIN_LEN) && (lo_len <= MAX_LEN);
  endfunction

  task automatic push_exp(input bit sel, input logic [23:0] w);
    frame_t f;
    f.sel     = sel;
    f.len     = 32'(w[11:0]);
    f.discard = !word_good(w);
    exp_q.push_back(f);
  endtask

  // Moves the staged words into the (empty) control FIFOs at once and
  // predicts the order in which they will be granted.
  task automatic load();
    int unsigned h = 0, l = 0;
    bit hi_ne, lo_ne, g_hi;
    while ((h < stage_hi.size()) || (l < stage_lo.size())) begin
      hi_ne = (h < stage_hi.size());
      lo_ne = (l < stage_lo.size());
      g_hi  = hi_ne && (!lo_ne || (m_streak != MAX_HI_BURST));
      if (g_hi) begin
        push_exp(1'b1, stage_hi[h]);
        h++;
        if (!lo_ne)                       m_streak = 0;
        else if (m_streak < MAX_HI_BURST) m_streak++;
      end else begin
        push_exp(1'b0, stage_lo[l]);
        l++;
        m_streak = 0;
      end
    end
    foreach (stage_hi[i]) hi_fifo.push_back(stage_hi[i]);
    foreach (stage_lo[i]) lo_fifo.push_back(stage_lo[i]);
    stage_hi.delete();
    stage_lo.delete();
    refresh();
  endtask

  task automatic finish_frame(input bit disc);
    frame_t f;
    if (exp_q.size() == 0) begin
      check("unexpected_frame", 32'd1, 32'd0);
    end else begin
      f = exp_q.pop_front();
      check("frame_sel", 32'(cur_sel), 32'(f.sel));
      check("frame_discard", 32'(disc), 32'(f.discard));
      check("frame_bytes", bytes, f.len);
      if (disc) check("disc_cycles", disc_cycles, (f.len == 0) ? 32'd1 : f.len);
    end
    in_frame = 0;
  endtask

  // Show-ahead FIFO pop lands just after the edge that consumed the word.
  always @(posedge clk_sys) begin
    #1;
    if (hi_pop && hi_fifo.size() != 0) hi_fifo.delete(0);
    if (lo_pop && lo_fifo.size() != 0) lo_fifo.delete(0);
    hi_pop = 0;
    lo_pop = 0;
    refresh();
  end

  always @(negedge clk_sys) begin
    if (reset) begin
      in_frame   = 0;
      gap_active = 0;
      prev_disc  = 0;
    end else begin
      if (gap_active) begin
        if (sched_busy && !hi_ctrl_rd && !lo_ctrl_rd) begin
          gap_cnt++;
        end else begin
          check("gap_len", gap_cnt, IFG_CYCLES);
          gap_active = 0;
        end
      end
      if (prev_disc && !m_discard_en) begin
        finish_frame(1'b1);
        check("disc_then_idle", 32'(sched_busy), 32'd0);
      end
      prev_disc = m_discard_en;
      if (hi_ctrl_rd || lo_ctrl_rd) begin
        check("one_ctrl_rd", 32'(hi_ctrl_rd & lo_ctrl_rd), 32'd0);
        check("ctrl_rd_nonempty", 32'(hi_ctrl_rd ? hi_ctrl_empty : lo_ctrl_empty), 32'd0);
        check("ctrl_rd_mid_frame", 32'(in_frame), 32'd0);
        in_frame    = 1;
        cur_sel     = hi_ctrl_rd;
        bytes       = 0;
        disc_cycles = 0;
        hi_pop      = hi_ctrl_rd;
        lo_pop      = lo_ctrl_rd;
      end
      if (m_discard_en) begin
        disc_cycles++;
        check("disc_no_strobes", 32'({tx_byte_valid, tx_sof, tx_eof}), 32'd0);
      end
      if (hi_data_rd || lo_data_rd) begin
        check("data_rd_sel", 32'({hi_data_rd, lo_data_rd}), cur_sel ? 32'd2 : 32'd1);
        check("tx_sel_stable", 32'(tx_sel), 32'(cur_sel));
        bytes++;
      end
      if (in_frame && !m_discard_en) begin
        check("valid_eq_rd", 32'(tx_byte_valid), 32'(hi_data_rd | lo_data_rd));
      end
      if (tx_byte_valid) begin
        check("valid_needs_ready", 32'(tx_byte_ready), 32'd1);
        check("sof", 32'(tx_sof), 32'(bytes == 1));
        if (tx_eof) begin
          finish_frame(1'b0);
          gap_active = 1;
          gap_cnt    = 0;
        end
      end
    end
  end

  task automatic wait_idle(input int unsigned budget);
    bit done = 0;
    for (int unsigned i = 0; i < budget; i++) begin
      @(negedge clk_sys);
      if (exp_q.size() == 0 && !sched_busy && hi_fifo.size() == 0 && lo_fifo.size() == 0) begin
        done = 1;
        break;
      end
    end
    if (!done) check("wait_idle_timeout", 32'd1, 32'd0);
    @(posedge clk_sys);
    #2;
  endtask

  function automatic logic [31:0] all_outputs();
    return 32'({hi_ctrl_rd, lo_ctrl_rd, hi_data_rd, lo_data_rd, tx_byte_valid, tx_sel,
                tx_sof, tx_eof, m_discard_en, sched_busy});
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    tx_byte_ready = 1'b1;
    refresh();
    repeat (3) @(posedge clk_sys);
    #1;
    check("reset_outputs", all_outputs(), 32'd0);
`ifdef SCHED_STATS_EN
    check("reset_stats", 32'({stat_hi_frames, stat_lo_frames} | 32'(stat_discards)), 32'd0);
`endif
    @(posedge clk_sys);
    #2;
    reset = 1'b0;
    @(posedge clk_sys);
    #2;

    // Single lo frame with latency probe.
    stage_lo.push_back(24'h040040);
    load();
    @(negedge clk_sys);
    check("lat_idle_no_rd", 32'({hi_ctrl_rd, lo_ctrl_rd}), 32'd0);
    @(negedge clk_sys);
    check("lat_ctrl_rd", 32'({hi_ctrl_rd, lo_ctrl_rd}), 32'd1);
    @(negedge clk_sys);
    check("lat_data_rd", 32'({lo_data_rd, tx_sof}), 32'd3);
    wait_idle(4000);

    // Both queues loaded: anti-starvation grant order.
    for (int i = 0; i < 8; i++) begin
      stage_hi.push_back(24'h040040);
      stage_lo.push_back(24'h040040);
    end
    load();
    wait_idle(4000);

    // Field mismatch discard followed directly by a good frame.
    stage_lo.push_back(24'h040041);
    stage_lo.push_back(24'h040040);
    load();
    wait_idle(4000);

    // Length boundaries: short, zero, MIN-1, MAX, MAX+1, MIN.
    stage_hi.push_back(24'h020020);
    stage_hi.push_back(24'h000000);
    stage_hi.push_back(24'h03F03F);
    stage_hi.push_back(24'h5EE5EE);
    stage_hi.push_back(24'h5EF5EF);
    stage_hi.push_back(24'h040040);
    load();
    wait_idle(8000);

    // Serializer back-pressure pattern 1,0,0,1.
    stage_lo.push_back(24'h040040);
    load();
    for (int i = 0; i < 400; i++) begin
      @(posedge clk_sys);
      #2;
      tx_byte_ready = ((i % 4) == 0) || ((i % 4) == 3);
      if (exp_q.size() == 0 && !sched_busy) break;
    end
    tx_byte_ready = 1'b1;
    wait_idle(4000);

    // Asynchronous reset in the middle of a transfer.
    stage_hi.push_back(24'h040040);
    load();
    repeat (20) @(posedge clk_sys);
    #2;
    check("pre_reset_busy", 32'(sched_busy), 32'd1);
    reset = 1'b1;
    #1;
    check("reset_mid_xfer", all_outputs(), 32'd0);
`ifdef SCHED_STATS_EN
    check("reset_mid_stats", 32'({stat_hi_frames, stat_lo_frames} | 32'(stat_discards)), 32'd0);
`endif
    exp_q.delete();
    hi_fifo.delete();
    lo_fifo.delete();
    hi_pop   = 0;
    lo_pop   = 0;
    m_streak = 0;
    refresh();
    repeat (2) @(posedge clk_sys);
    #2;
    reset = 1'b0;
    @(posedge clk_sys);
    #2;
    stage_lo.push_back(24'h040040);
    load();
    wait_idle(4000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
